mcu_controller: RTL and testbench
=================================

MCU_CONTROLLER -- requirements
Module: mcu_controller

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning): none; all widths are fixed at 3-bit opcode and 8-bit retire count.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
  clk  input  1  single system clock; all state changes on the rising edge.
  rst  input  1  synchronous, active-high reset.
  en  input  1  run enable; 0 freezes the sequencer.
  opcode  input  3  instruction register opcode field.
  zero  input  1  accumulator-equals-zero flag.
  sel  output  1  address mux select; 1 = PC, 0 = IR operand address.
  rd  output  1  memory read enable.
  wr  output  1  memory write strobe.
  ld_ir  output  1  instruction register load strobe.
  ld_ac  output  1  accumulator load strobe.
  inc_pc  output  1  PC increment strobe.
  ld_pc  output  1  PC load (jump) strobe.
  data_e  output  1  accumulator-to-bus drive enable.
  alu_op  output  3  ALU operation select.
  halt  output  1  processor halted.
  retired  output  8  count of completed instructions.

Function
REQ-003 Opcode encoding SHALL be: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111. ALUOP SHALL mean ADD, AND, XOR or LDA.
REQ-004 The sequencer SHALL be a Moore FSM with states P0..P7 (INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE) and HALTED.
REQ-005 With en=1, the state SHALL advance P0->P1->...->P7->P0, one state per clock.
REQ-006 With en=0, the state and retired SHALL hold, and the single-cycle strobes (ld_ir, ld_ac, inc_pc, ld_pc, wr) SHALL be 0; the level outputs sel, rd, data_e and alu_op SHALL keep their state-decoded values.
REQ-007 Outputs in P0..P3 SHALL be:
  P0: sel=1.
  P1: sel=1, rd=1.
  P2: sel=1, rd=1, ld_ir=1.
  P3: sel=1, rd=1.
  All other outputs SHALL be 0 in these states.
REQ-008 P4 SHALL assert inc_pc=1. If opcode=HLT, P4 SHALL also assert halt=1, and the next state SHALL be HALTED instead of P5.
REQ-009 Outputs in P5..P7 SHALL be:
  P5: rd=ALUOP.
  P6: rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO).
  P7: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO).
REQ-010 alu_op SHALL equal opcode in P5..P7 and 3'b000 (pass-through) in every other state.
REQ-011 retired SHALL increment by 1 on the P7->P0 transition and wrap from 255 to 0. An instruction that halts SHALL not be counted.
REQ-012 HALTED SHALL hold halt=1 with all other outputs 0, and SHALL be left only by rst; en SHALL have no effect in HALTED.
REQ-013 opcode and zero SHALL be sampled combinationally in the current state; the block SHALL NOT register them.

Reset
REQ-014 When rst=1 at a clock edge, the state SHALL become P0, retired SHALL become 0 and halt SHALL become 0. This SHALL hold in any state, including mid-instruction and in HALTED.
REQ-015 rst SHALL take priority over en.
REQ-016 The outputs after reset SHALL be the P0 values: sel=1 and all others 0.

Structure
REQ-017 The opcode localparams and the state encoding SHALL live in a shared package (mcu_pkg), which the datapath also uses for alu_op.
REQ-018 The block SHALL be a single module with no sub-modules; the output decode SHALL be one combinational block driven from the state register.

Verification
REQ-019 Reset then opcode=ADD, en=1 for 8 clocks -> rd high in P1..P3 and P5..P7, ld_ir in P2 only, ld_ac in P7 only, alu_op=010 in P5..P7, retired=1.
REQ-020 opcode=STO -> wr=1 in P7 only, data_e=1 in P6..P7, rd=0 in P5..P7.
REQ-021 opcode=SKZ with zero=1 -> inc_pc pulses in P4 and P6; with zero=0 -> inc_pc pulses in P4 only.
REQ-022 opcode=HLT -> halt=1 from P4 onward, state stays HALTED for 20 clocks, retired is unchanged; then rst -> P0 with halt=0.
REQ-023 en=0 held for 3 clocks in P2 -> ld_ir=0 while frozen; the state stays P2; ld_ir fires once after en returns to 1.
REQ-024 Run 256 JMP instructions -> ld_pc=1 in P6 and P7 of each instruction, and retired wraps to 0.

Source files
------------

// File: rtl/mcu_pkg.sv
// mcu_pkg: shared definitions for the MCU sequencer and its datapath.
//   - opcode encodings (3-bit instruction register field)
//   - sequencer state encoding (P0..P7 plus HALTED)
//   - is_aluop(): true for opcodes whose operand is read from memory and
//     whose result is loaded into the accumulator (ADD, AND, XOR, LDA)
package mcu_pkg;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  // ALU select value used outside the operand phases: operand passes through.
  localparam logic [2:0] ALU_PASS = 3'b000;

  typedef enum logic [3:0] {
    P0_INST_ADDR  = 4'd0,
    P1_INST_FETCH = 4'd1,
    P2_INST_LOAD  = 4'd2,
    P3_IDLE       = 4'd3,
    P4_OP_ADDR    = 4'd4,
    P5_OP_FETCH   = 4'd5,
    P6_ALU_OP     = 4'd6,
    P7_STORE      = 4'd7,
    HALTED        = 4'd8
  } state_t;

  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/mcu_controller.sv
// mcu_controller: eight-phase Moore instruction sequencer for a small
// accumulator MCU.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset (to P0, retired=0)
//   en       - run enable; 0 freezes state and suppresses the strobes
//   opcode   - instruction register opcode field (used combinationally)
//   zero     - accumulator-equals-zero flag (used combinationally)
//   sel      - address mux select, 1 = PC, 0 = IR operand address
//   rd       - memory read enable
//   wr       - memory write strobe
//   ld_ir    - instruction register load strobe
//   ld_ac    - accumulator load strobe
//   inc_pc   - PC increment strobe
//   ld_pc    - PC load (jump) strobe
//   data_e   - accumulator-to-bus drive enable
//   alu_op   - ALU operation select (opcode in P5..P7, pass otherwise)
//   halt     - processor halted
//   retired  - count of completed instructions, wraps at 256
module mcu_controller
  import mcu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       wr,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       data_e,
  output logic [2:0] alu_op,
  output logic       halt,
  output logic [7:0] retired
);

  state_t     state;
  logic [7:0] retired_cnt;

  assign retired = retired_cnt;

  // State register: HALTED is absorbing until reset, so en is ignored there.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= P0_INST_ADDR;
      retired_cnt <= 8'd0;
    end else if (en && (state != HALTED)) begin
      unique case (state)
        P0_INST_ADDR:  state <= P1_INST_FETCH;
        P1_INST_FETCH: state <= P2_INST_LOAD;
        P2_INST_LOAD:  state <= P3_IDLE;
        P3_IDLE:       state <= P4_OP_ADDR;
        P4_OP_ADDR:    state <= (opcode == OP_HLT) ? HALTED : P5_OP_FETCH;
        P5_OP_FETCH:   state <= P6_ALU_OP;
        P6_ALU_OP:     state <= P7_STORE;
        P7_STORE: begin
          state       <= P0_INST_ADDR;
          retired_cnt <= retired_cnt + 8'd1;
        end
        default:       state <= P0_INST_ADDR;
      endcase
    end
  end

  // Output decode. Level outputs follow the state alone; single-cycle
  // strobes are gated by en so a frozen sequencer never repeats an action.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    alu_op = ALU_PASS;
    halt   = 1'b0;
    unique case (state)
      P0_INST_ADDR: begin
        sel = 1'b1;
      end
      P1_INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      P2_INST_LOAD: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = en;
      end
      P3_IDLE: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      P4_OP_ADDR: begin
        inc_pc = en;
        halt   = (opcode == OP_HLT);
      end
      P5_OP_FETCH: begin
        rd     = is_aluop(opcode);
        alu_op = opcode;
      end
      P6_ALU_OP: begin
        rd     = is_aluop(opcode);
        alu_op = opcode;
        inc_pc = en && (opcode == OP_SKZ) && zero;
        ld_pc  = en && (opcode == OP_JMP);
        data_e = (opcode == OP_STO);
      end
      P7_STORE: begin
        rd     = is_aluop(opcode);
        alu_op = opcode;
        ld_ac  = en && is_aluop(opcode);
        ld_pc  = en && (opcode == OP_JMP);
        wr     = en && (opcode == OP_STO);
        data_e = (opcode == OP_STO);
      end
      HALTED: begin
        halt = 1'b1;
      end
      default: begin
        sel = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mcu_controller.sv
// Self-checking bench for mcu_controller. Each cycle the bench computes the
// expected output vector from its own phase tracker, queues it, and compares
// it against the sampled outputs at the falling edge.
module tb_mcu_controller;

  localparam logic [2:0] HLT = 3'b000;
  localparam logic [2:0] SKZ = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] ANDI = 3'b011;
  localparam logic [2:0] XORI = 3'b100;
  localparam logic [2:0] LDA = 3'b101;
  localparam logic [2:0] STO = 3'b110;
  localparam logic [2:0] JMP = 3'b111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic       zero = 1'b0;
  logic       sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt;
  logic [2:0] alu_op;
  logic [7:0] retired;

  int vectors = 0;
  int miscompares = 0;

  // Model of the sequencer: phase 0..7, 8 = halted.
  int         ms = 0;
  logic [7:0] mret = 8'd0;
  logic [19:0] last;
  logic [19:0] expq[$];

  mcu_controller dut (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .wr(wr), .ld_ir(ld_ir), .ld_ac(ld_ac),
    .inc_pc(inc_pc), .ld_pc(ld_pc), .data_e(data_e), .alu_op(alu_op),
    .halt(halt), .retired(retired)
  );

  always #5 clk = ~clk;

  // Packing: {sel,rd,wr,ld_ir,ld_ac,inc_pc,ld_pc,data_e,alu_op[2:0],halt,retired[7:0]}
  function automatic logic [19:0] expv(int s, logic e, logic [2:0] op, logic z, logic [7:0] r);
    logic s_, rd_, wr_, ir_, ac_, inc_, lpc_, de_, h_;
    logic [2:0] a_;
    logic mem;
    mem = (op == ADD) || (op == ANDI) || (op == XORI) || (op == LDA);
    {s_, rd_, wr_, ir_, ac_, inc_, lpc_, de_, h_} = '0;
    a_ = 3'b000;
    case (s)
      0: s_ = 1;
      1: begin s_ = 1; rd_ = 1; end
      2: begin s_ = 1; rd_ = 1; ir_ = e; end
      3: begin s_ = 1; rd_ = 1; end
      4: begin inc_ = e; h_ = (op == HLT); end
      5: begin rd_ = mem; a_ = op; end
      6: begin rd_ = mem; a_ = op; inc_ = e && op == SKZ && z; lpc_ = e && op == JMP; de_ = op == STO; end
      7: begin rd_ = mem; a_ = op; ac_ = e && mem; lpc_ = e && op == JMP; wr_ = e && op == STO; de_ = op == STO; end
      default: h_ = 1;
    endcase
    return {s_, rd_, wr_, ir_, ac_, inc_, lpc_, de_, a_, h_, r};
  endfunction

  // Entered and left at posedge+1: drive, predict, sample at negedge,
  // then advance the model across the next rising edge.
  task automatic step(input logic e, input logic [2:0] op, input logic z);
    logic [19:0] want;
    en = e; opcode = op; zero = z;
    expq.push_back(expv(ms, e, op, z, mret));
    @(negedge clk);
    last = {sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, alu_op, halt, retired};
    want = expq.pop_front();
    vectors++;
    if (last !== want) begin
      miscompares++;
      $display("FAIL outputs phase%0d op=%b en=%b z=%b: got %b expected %b", ms, op, e, z, last, want);
    end
    if (ms != 8 && e) begin
      if (ms == 4 && op == HLT) ms = 8;
      else if (ms == 7) begin ms = 0; mret = mret + 8'd1; end
      else ms = ms + 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ms = 0; mret = 8'd0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors++;
    if ({sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, alu_op, halt, retired} !== 20'b1000_0000_0000_0000_0000) begin
      miscompares++;
      $display("FAIL reset_state: got sel=%b rd=%b halt=%b alu_op=%b retired=%0d, expected sel=1 rest 0",
               sel, rd, halt, alu_op, retired);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int nrd = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, ADD, 1'b0);
      if (last[18]) nrd++;
    end
    vectors++;
    if (retired !== 8'd1 || nrd != 6) begin
      miscompares++;
      $display("FAIL add_instr: retired=%0d rd_cycles=%0d, expected 1 and 6", retired, nrd);
    end
  endtask

  task automatic test_sto();
    int nwr = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, STO, 1'b1);
      if (last[17]) nwr++;
    end
    vectors++;
    if (nwr != 1) begin
      miscompares++;
      $display("FAIL sto_wr_count: got %0d expected 1", nwr);
    end
  endtask

  task automatic test_skz();
    int n1 = 0, n0 = 0;
    for (int i = 0; i < 8; i++) begin step(1'b1, SKZ, 1'b1); if (last[14]) n1++; end
    for (int i = 0; i < 8; i++) begin step(1'b1, SKZ, 1'b0); if (last[14]) n0++; end
    vectors++;
    if (n1 != 2 || n0 != 1) begin
      miscompares++;
      $display("FAIL skz_inc_pc: got %0d/%0d expected 2/1", n1, n0);
    end
  endtask

  task automatic test_freeze();
    int nir = 0;
    step(1'b1, LDA, 1'b0);
    step(1'b1, LDA, 1'b0);
    for (int i = 0; i < 3; i++) begin step(1'b0, LDA, 1'b0); if (last[16]) nir++; end
    for (int i = 0; i < 6; i++) begin step(1'b1, LDA, 1'b0); if (last[16]) nir++; end
    vectors++;
    if (nir != 1) begin
      miscompares++;
      $display("FAIL freeze_ld_ir: got %0d pulses expected 1", nir);
    end
  endtask

  task automatic test_halt();
    logic [7:0] r0;
    r0 = mret;
    for (int i = 0; i < 5; i++) step(1'b1, HLT, 1'b0);
    for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    vectors++;
    if (halt !== 1'b1 || retired !== r0) begin
      miscompares++;
      $display("FAIL halted_hold: halt=%b retired=%0d expected 1 and %0d", halt, retired, r0);
    end
    do_reset();
    step(1'b1, ADD, 1'b0);
    // Reset mid-instruction, in P5.
    for (int i = 0; i < 4; i++) step(1'b1, XORI, 1'b0);
    do_reset();
    step(1'b1, XORI, 1'b0);
  endtask

  task automatic test_jmp_wrap();
    int npc = 0;
    do_reset();
    for (int i = 0; i < 256 * 8; i++) begin
      step(1'b1, JMP, 1'b0);
      if (last[13]) npc++;
    end
    vectors++;
    if (npc != 512 || retired !== 8'd0) begin
      miscompares++;
      $display("FAIL jmp_wrap: ld_pc=%0d retired=%0d expected 512 and 0", npc, retired);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if (op == HLT && $urandom_range(0, 3) != 0) op = ADD;
      step(1'($urandom_range(0, 3) != 0), op, 1'($urandom_range(0, 1)));
    end
    do_reset();
    step(1'b0, ADD, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_add();
    test_sto();
    test_skz();
    test_freeze();
    test_halt();
    test_jmp_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
